// File: rtl/urng_sched_pkg.sv
// urng_sched_pkg: shared states, seed guard constants and defaults for the URNG scheduler
package urng_sched_pkg;
  typedef enum logic [1:0] {IDLE, SEED, WARM, RUN} state_t;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WARMUP = 8;
  localparam logic [31:0] G0 = 32'h2, G1 = 32'h8, G2 = 32'h10;
  localparam logic [31:0] T0 = 32'd2, T1 = 32'd8, T2 = 32'd16;
  function automatic logic [31:0] guard(input logic [31:0] s, input logic [31:0] thr, input logic [31:0] g);
    return (s < thr) ? (s | g) : s;
  endfunction
endpackage

// File: rtl/urng_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; ports req/ptr in, one-hot gnt and winner index out
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       win
);
  int best, d;
  always_comb begin
    best = N_REQ;
    d = 0;
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i >= int'(ptr)) ? i - int'(ptr) : i + N_REQ - int'(ptr);
      if (req[i] && d < best) begin
        best = d;
        win = 3'(i);
      end
    end
    gnt = {{(N_REQ-1){1'b0}}, |req} << win;
  end
endmodule

// File: rtl/urng_sched.sv
// urng_sched: seeds/warms the shared Tausworthe URNG and deals its words round-robin to requesters; ports: clk, rst (async active-low), seed_req/seed0..2 in, urng_rst_n/urng_seed0..2 to URNG, urng_out from URNG, req/gnt handshake, rnd_data/rnd_valid/rnd_id delivery, busy, word_cnt
module urng_sched
  import urng_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WARMUP = DEF_WARMUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_req,
  input  logic [31:0]      seed0,
  input  logic [31:0]      seed1,
  input  logic [31:0]      seed2,
  output logic             urng_rst_n,
  output logic [31:0]      urng_seed0,
  output logic [31:0]      urng_seed1,
  output logic [31:0]      urng_seed2,
  input  logic [31:0]      urng_out,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rnd_data,
  output logic             rnd_valid,
  output logic [2:0]       rnd_id,
  output logic             busy,
  output logic [15:0]      word_cnt
);
  state_t state, nxt;
  logic [31:0] s0, s1, s2;
  logic [7:0] wcnt;
  logic [2:0] ptr, win;
  logic [N_REQ-1:0] arb_gnt;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(req), .ptr(ptr), .gnt(arb_gnt), .win(win));
  assign gnt = (state == RUN) ? arb_gnt : '0;
  assign busy = state != RUN;
  assign urng_seed0 = guard(s0, T0, G0);
  assign urng_seed1 = guard(s1, T1, G1);
  assign urng_seed2 = guard(s2, T2, G2);
  always_comb begin
    nxt = (seed_req && state != SEED) ? SEED :
          (state == SEED) ? WARM :
          (state == WARM && wcnt == 8'(WARMUP-1)) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      urng_rst_n <= 1'b0;
      {s0, s1, s2} <= '0;
      wcnt <= '0;
      ptr <= '0;
      rnd_data <= '0;
      rnd_valid <= 1'b0;
      rnd_id <= '0;
      word_cnt <= '0;
    end else begin
      state <= nxt;
      // URNG runs only while warming or serving; held in load during IDLE/SEED
      urng_rst_n <= (nxt == WARM) || (nxt == RUN);
      wcnt <= (state == WARM) ? wcnt + 8'd1 : '0;
      rnd_valid <= |gnt;
      if (seed_req && state != SEED) begin
        s0 <= seed0;
        s1 <= seed1;
        s2 <= seed2;
      end
      if (|gnt) begin
        rnd_data <= urng_out;
        rnd_id <= win;
        word_cnt <= word_cnt + 16'd1;
        ptr <= (win == 3'(N_REQ-1)) ? 3'd0 : win + 3'd1;
      end
      // a grant on the seed_req cycle still lands above, then SEED wipes the bookkeeping
      if (state == SEED) begin
        word_cnt <= '0;
        ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_urng_sched.sv
// tb_urng_sched: directed self-checking bench for urng_sched
module tb_urng_sched;
  localparam int WARMUP = 8;
  logic clk = 1'b0, rst = 1'b0, seed_req = 1'b0;
  logic [31:0] seed0 = '0, seed1 = '0, seed2 = '0, urng_out = '0;
  logic [3:0] req = '0;
  logic urng_rst_n, rnd_valid, busy;
  logic [31:0] urng_seed0, urng_seed1, urng_seed2, rnd_data;
  logic [3:0] gnt;
  logic [2:0] rnd_id;
  logic [15:0] word_cnt;
  int checks = 0, failures = 0;

  urng_sched #(.N_REQ(4), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .seed_req(seed_req), .seed0(seed0), .seed1(seed1), .seed2(seed2),
    .urng_rst_n(urng_rst_n), .urng_seed0(urng_seed0), .urng_seed1(urng_seed1), .urng_seed2(urng_seed2),
    .urng_out(urng_out), .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_id(rnd_id), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    seed_req = 1'b1; seed0 = a; seed1 = b; seed2 = c;
    @(negedge clk);
    seed_req = 1'b0;
    repeat (WARMUP + 1) @(negedge clk);
  endtask

  task automatic test_reset;
    req = 4'b1111;
    #1;
    checks++; if (urng_rst_n !== 1'b0) begin failures++; $display("FAIL reset_urng_rst_n got=%0h exp=0", urng_rst_n); end
    checks++; if ({urng_seed0, urng_seed1, urng_seed2} !== {32'h2, 32'h8, 32'h10}) begin failures++; $display("FAIL reset_seeds got=%h %h %h exp=2 8 10", urng_seed0, urng_seed1, urng_seed2); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if ({rnd_data, rnd_valid, rnd_id} !== 36'h0) begin failures++; $display("FAIL reset_rnd got=%h/%b/%0d exp=0/0/0", rnd_data, rnd_valid, rnd_id); end
    checks++; if (busy !== 1'b1 || word_cnt !== 16'd0) begin failures++; $display("FAIL reset_busy_cnt got=%b/%0d exp=1/0", busy, word_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL idle_gnt got=%b/%b exp=0000/1", gnt, busy); end
  endtask

  task automatic test_seed;
    @(negedge clk);
    seed_req = 1'b1; seed0 = 32'd1; seed1 = 32'd2; seed2 = 32'd3;
    @(negedge clk);
    seed_req = 1'b0;
    checks++; if (urng_rst_n !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL seed_state got=%b/%b/%b exp=0/1/0000", urng_rst_n, busy, gnt); end
    for (int k = 0; k < WARMUP; k++) begin
      @(negedge clk);
      checks++; if (urng_rst_n !== 1'b1 || busy !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL warm_%0d got=%b/%b/%b exp=1/1/0000", k, urng_rst_n, busy, gnt); end
      if (k == 0) begin
        checks++; if ({urng_seed0, urng_seed1, urng_seed2} !== {32'h3, 32'hA, 32'h13}) begin failures++; $display("FAIL guarded_seeds got=%h %h %h exp=3 a 13", urng_seed0, urng_seed1, urng_seed2); end
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy got=%b exp=0", busy); end
    req = 4'b0000;
  endtask

  task automatic test_rr;
    logic [31:0] prev;
    prev = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (rnd_valid !== 1'b1 || rnd_id !== 3'((k-1) % 4) || rnd_data !== prev) begin failures++; $display("FAIL rr_data_%0d got=%b/%0d/%h exp=1/%0d/%h", k-1, rnd_valid, rnd_id, rnd_data, (k-1) % 4, prev); end
        checks++; if (word_cnt !== 16'(k)) begin failures++; $display("FAIL rr_cnt_%0d got=%0d exp=%0d", k-1, word_cnt, k); end
      end
      if (k == 8) begin
        req = 4'b0000;
      end else begin
        req = 4'b1111;
        prev = 32'hC0DE0000 + 32'(k) * 32'h1111;
        urng_out = prev;
        #1;
        checks++; if (gnt !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_gnt_%0d got=%b exp=%b", k, gnt, 4'(1 << (k % 4))); end
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] exp3 [3];
    exp3 = '{4'b1000, 4'b0001, 4'b0010};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = 4'b0100;
      #1;
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt_%0d got=%b exp=0100", k, gnt); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 4'b1011;
      #1;
      checks++; if (gnt !== exp3[k]) begin failures++; $display("FAIL mixed_gnt_%0d got=%b exp=%b", k, gnt, exp3[k]); end
    end
    @(negedge clk);
    req = 4'b0000;
    checks++; if (rnd_id !== 3'd1 || rnd_valid !== 1'b1) begin failures++; $display("FAIL mixed_id got=%0d/%b exp=1/1", rnd_id, rnd_valid); end
  endtask

  task automatic test_reseed;
    @(negedge clk);
    req = 4'b1111;
    seed_req = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL reseed_last_gnt got=%b exp=0100", gnt); end
    @(negedge clk);
    seed_req = 1'b0;
    #1;
    checks++; if (rnd_valid !== 1'b1 || rnd_id !== 3'd2) begin failures++; $display("FAIL reseed_last_word got=%b/%0d exp=1/2", rnd_valid, rnd_id); end
    checks++; if (gnt !== 4'b0000 || urng_rst_n !== 1'b0) begin failures++; $display("FAIL reseed_seed got=%b/%b exp=0000/0", gnt, urng_rst_n); end
    for (int k = 0; k < WARMUP; k++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reseed_warm_%0d got=%b exp=0000", k, gnt); end
    end
    @(negedge clk);
    #1;
    checks++; if (gnt !== 4'b0001 || word_cnt !== 16'd0) begin failures++; $display("FAIL reseed_first got=%b/%0d exp=0001/0", gnt, word_cnt); end
    @(negedge clk);
    req = 4'b0000;
    checks++; if (rnd_valid !== 1'b1 || rnd_id !== 3'd0 || word_cnt !== 16'd1) begin failures++; $display("FAIL reseed_word got=%b/%0d/%0d exp=1/0/1", rnd_valid, rnd_id, word_cnt); end
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL pre_rst_gnt got=%b exp=0010", gnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rnd_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1 || urng_rst_n !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl got=%b/%b/%b/%b exp=0/0000/1/0", rnd_valid, gnt, busy, urng_rst_n); end
    checks++; if (rnd_data !== 32'h0 || rnd_id !== 3'd0 || word_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_data got=%h/%0d/%0d exp=0/0/0", rnd_data, rnd_id, word_cnt); end
    checks++; if ({urng_seed0, urng_seed1, urng_seed2} !== {32'h2, 32'h8, 32'h10}) begin failures++; $display("FAIL mid_rst_seeds got=%h %h %h exp=2 8 10", urng_seed0, urng_seed1, urng_seed2); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin failures++; $display("FAIL post_rst_idle_%0d got=%b/%b exp=0000/0", k, gnt, rnd_valid); end
    end
    do_seed(32'd5, 32'd9, 32'd17);
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL post_rst_first got=%b exp=0001", gnt); end
    req = 4'b0000;
  endtask

  task automatic test_wrap;
    req = 4'b0001;
    repeat (65535) @(negedge clk);
    checks++; if (word_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", word_cnt); end
    @(negedge clk);
    checks++; if (word_cnt !== 16'h0000 || rnd_valid !== 1'b1 || gnt !== 4'b0001) begin failures++; $display("FAIL wrap got=%h/%b/%b exp=0000/1/0001", word_cnt, rnd_valid, gnt); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_seed;
    test_rr;
    test_single;
    test_reseed;
    test_rst_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
